// File: rtl/sfifo_param.sv
// sfifo_param -- parametrised single-clock synchronous FIFO.
//
// Purpose: buffer between the GPIF slave-FIFO state machine and the user-side
// data source/sink. Writes and reads are only acted on when accepted; all
// status flags decode from the registered occupancy count, so no flag has a
// combinational path from any input.
//
// Optional feature: define SFIFO_PARAM_ERR_FLAGS_EN to build sticky
// overflow/underflow error flags; otherwise both are tied to 0.
//
// Ports:
//   fifo_clk      in   clock, rising edge
//   reset_        in   synchronous active-low reset
//   fifo_flush    in   synchronous flush (empties FIFO, clears errors, holds dout)
//   din           in   write data
//   write_busy    in   write request
//   read_busy     in   read request
//   dout          out  registered read data
//   dout_valid    out  dout holds a word popped on the previous edge
//   fifo_full     out  occupancy == DEPTH
//   fifo_empty    out  occupancy == 0
//   almost_full   out  occupancy >= AF_THRESH
//   almost_empty  out  occupancy <= AE_THRESH
//   occupancy     out  word count 0..DEPTH
//   overflow_err  out  sticky: write requested while full
//   underflow_err out  sticky: read requested while empty
module sfifo_param #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int AF_THRESH  = (1 << DEPTH_LOG2) - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                  fifo_clk,
  input  logic                  reset_,
  input  logic                  fifo_flush,
  input  logic [WIDTH-1:0]      din,
  input  logic                  write_busy,
  output logic                  fifo_full,
  output logic                  almost_full,
  input  logic                  read_busy,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic                  fifo_empty,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   occupancy,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] AF_C    = AF_THRESH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] AE_C    = AE_THRESH[DEPTH_LOG2:0];

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   occ_q, occ_d;
  logic [WIDTH-1:0]      dout_q;
  logic                  dout_valid_q;
  logic                  wr_acc, rd_acc;

  // Flags come from the registered count only.
  assign fifo_full    = (occ_q == DEPTH_C);
  assign fifo_empty   = (occ_q == '0);
  assign almost_full  = (occ_q >= AF_C);
  assign almost_empty = (occ_q <= AE_C);
  assign occupancy    = occ_q;
  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;

  // Full+both: only the read goes; empty+both: only the write goes.
  assign wr_acc = write_busy & ~fifo_full  & ~fifo_flush;
  assign rd_acc = read_busy  & ~fifo_empty & ~fifo_flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Storage has no reset; contents after reset/flush are don't-care.
  always_ff @(posedge fifo_clk) begin
    if (wr_acc) mem[wptr_q] <= din;
  end

  always_ff @(posedge fifo_clk) begin
    if (!reset_) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      occ_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else if (fifo_flush) begin
      // dout is deliberately held across a flush
      wptr_q       <= '0;
      rptr_q       <= '0;
      occ_q        <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      occ_q        <= occ_d;
      dout_valid_q <= rd_acc;
      if (rd_acc) dout_q <= mem[rptr_q];
    end
  end

`ifdef SFIFO_PARAM_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  // Errors watch raw requests, not accepted ones; flush/reset win.
  always_ff @(posedge fifo_clk) begin
    if (!reset_ || fifo_flush) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (write_busy && fifo_full)  ovf_q <= 1'b1;
      if (read_busy  && fifo_empty) udf_q <= 1'b1;
    end
  end

  assign overflow_err  = ovf_q;
  assign underflow_err = udf_q;
`else
  assign overflow_err  = 1'b0;
  assign underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_sfifo_param.sv
// Scoreboarded bench for sfifo_param (DEPTH=8). A queue-based reference model
// tracks contents/flags; popped words go to an expect queue that an
// independent monitor drains whenever the DUT raises dout_valid.
module tb_sfifo_param;
  localparam int W  = 16;
  localparam int DL = 3;
  localparam int D  = 1 << DL;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          fifo_clk = 1'b0;
  logic          reset_, fifo_flush, write_busy, read_busy;
  logic [W-1:0]  din;
  logic          fifo_full, almost_full, dout_valid, fifo_empty, almost_empty;
  logic [W-1:0]  dout;
  logic [DL:0]   occupancy;
  logic          overflow_err, underflow_err;

  sfifo_param #(.WIDTH(W), .DEPTH_LOG2(DL), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .fifo_clk(fifo_clk), .reset_(reset_), .fifo_flush(fifo_flush), .din(din),
    .write_busy(write_busy), .fifo_full(fifo_full), .almost_full(almost_full),
    .read_busy(read_busy), .dout(dout), .dout_valid(dout_valid),
    .fifo_empty(fifo_empty), .almost_empty(almost_empty), .occupancy(occupancy),
    .overflow_err(overflow_err), .underflow_err(underflow_err));

  always #5 fifo_clk = ~fifo_clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_dout = '0;
  logic         m_vld = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
`ifdef SFIFO_PARAM_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model on the edge, check state.
  task automatic step(input bit rst, input bit fl, input bit wb, input bit rb,
                      input logic [W-1:0] d);
    bit full, empty, rd, wr;
    reset_ = ~rst; fifo_flush = fl; write_busy = wb; read_busy = rb; din = d;
    @(posedge fifo_clk);
    full  = (mq.size() == D);
    empty = (mq.size() == 0);
    if (rst || fl) begin
      mq.delete();
      m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      if (rst) m_dout = '0;
    end else begin
      if (ERR_EN && wb && full)  m_ovf = 1'b1;
      if (ERR_EN && rb && empty) m_udf = 1'b1;
      rd = rb && !empty;
      wr = wb && !full;
      m_vld = rd;
      if (rd) begin
        m_dout = mq.pop_front();
        exp_q.push_back(m_dout);
      end
      if (wr) mq.push_back(d);
    end
    @(negedge fifo_clk);
    chk("occupancy",    32'(occupancy),    32'(mq.size()));
    chk("fifo_empty",   32'(fifo_empty),   32'(mq.size() == 0));
    chk("fifo_full",    32'(fifo_full),    32'(mq.size() == D));
    chk("almost_full",  32'(almost_full),  32'(mq.size() >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= AE));
    chk("dout_valid",   32'(dout_valid),   32'(m_vld));
    chk("dout",         32'(dout),         32'(m_dout));
    chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
    chk("underflow_err",32'(underflow_err),32'(m_udf));
  endtask

  // Monitor: every presented word must be the next expected one.
  always @(negedge fifo_clk) begin
    if (dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: got %0h expected none", dout);
      end else begin
        chk("sb_data", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset_ = 1'b0; fifo_flush = 1'b0; write_busy = 1'b0; read_busy = 1'b0; din = '0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 16'h1234);           // reset overrides requests
    // write 1..8 back-to-back -> full
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 0, W'(i));
    chk("occ_after_8", 32'(occupancy), 32'd8);
    step(0, 0, 1, 0, 16'hDEAD);           // dropped, overflow event
    step(0, 0, 1, 1, 16'hBEEF);           // full + both: read only
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);                  // underflow event
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);                  // flush clears errors
    // occupancy 4, then 3*DEPTH cycles of simultaneous read/write
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, W'(16'h100 + i));
    for (int i = 0; i < 3 * D; i++) step(0, 0, 1, 1, W'(16'h200 + i));
    chk("occ_steady", 32'(occupancy), 32'd4);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    // empty + both: write only
    step(0, 0, 1, 1, 16'h0055);
    chk("occ_empty_both", 32'(occupancy), 32'd1);
    step(0, 0, 0, 1, 0);
    chk("dout_55", 32'(dout), 32'h55);
    // occupancy 5, flush with write
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, W'(16'h300 + i));
    step(0, 1, 1, 0, 16'h0777);
    chk("occ_flush", 32'(occupancy), 32'd0);
    // occupancy 6, one-cycle reset, then write
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, W'(16'h400 + i));
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 16'h0999);
    chk("occ_post_rst", 32'(occupancy), 32'd1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, f, wb, rb;
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 99) == 0);
      wb = ($urandom_range(0, 99) < ((i / 300) % 2 ? 70 : 35));
      rb = ($urandom_range(0, 99) < ((i / 300) % 2 ? 35 : 70));
      step(r, f, wb, rb, W'($urandom));
    end
    step(0, 0, 0, 0, 0);
    @(negedge fifo_clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sfifo_param.md
# sfifo_param

Parametrised single-clock synchronous FIFO, successor to the fixed 32×256 slave-FIFO buffer in the FPGA slave-FIFO data path. Width and depth are configurable. Adds accept-gated writes, a live occupancy output, programmable almost-full/almost-empty flags and a read-data valid strobe. Optional sticky overflow/underflow error flags replace simulation-only overflow/underflow checks. Sits between the GPIF slave-FIFO state machine and the user-side data source/sink.

## Interface
Parameters:
- WIDTH, 32, data width in bits (≥1)
- DEPTH_LOG2, 8, log2 of depth; DEPTH = 2**DEPTH_LOG2 (DEPTH_LOG2 ≥ 2)
- AF_THRESH, DEPTH-4, almost_full asserts when occupancy ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 4, almost_empty asserts when occupancy ≤ AE_THRESH (0..DEPTH-1)

Ports:
- fifo_clk  input  1  single clock; all logic on rising edge
- reset_  input  1  synchronous active-low reset, sampled on fifo_clk
- fifo_flush  input  1  synchronous flush; empties FIFO
- din  input  WIDTH  write data
- write_busy  input  1  write request
- fifo_full  output  1  occupancy == DEPTH
- almost_full  output  1  occupancy ≥ AF_THRESH
- read_busy  input  1  read request
- dout  output  WIDTH  read data, registered
- dout_valid  output  1  dout carries a newly popped word this cycle
- fifo_empty  output  1  occupancy == 0
- almost_empty  output  1  occupancy ≤ AE_THRESH
- occupancy  output  DEPTH_LOG2+1  current word count, 0..DEPTH
- overflow_err  output  1  sticky: write attempted while full
- underflow_err  output  1  sticky: read attempted while empty

## Operation
- Accepted write: wr_acc = write_busy & ~fifo_full & ~fifo_flush. Only on wr_acc: mem[write_ptr] <= din, write_ptr += 1. Rejected writes do not touch memory.
- Accepted read: rd_acc = read_busy & ~fifo_empty & ~fifo_flush. On rd_acc: dout <= mem[read_ptr], read_ptr += 1, dout_valid <= 1. Otherwise dout holds its value and dout_valid <= 0.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH without special handling.
- occupancy next = occupancy + wr_acc − rd_acc. Both accepted: unchanged.
- All flags decode combinationally from the registered occupancy only. There is no combinational path from any input to any flag.
- Full + read_busy + write_busy: read accepted, write rejected. No pass-through; the FIFO is not full next cycle.
- Empty + read_busy + write_busy: write accepted, read rejected (underflow event). No bypass.
- fifo_flush (while reset_=1): pointers, occupancy and dout_valid go to 0; error flags are cleared; dout is held; memory contents are don't-care. Flush overrides same-cycle reads and writes.
- reset_=0 at an edge: same as flush, plus dout <= 0. Mid-operation reset discards all contents. The first write is accepted on the first edge with reset_=1.

## Timing
- Reset values: dout=0, dout_valid=0, occupancy=0, fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0 (unless AF_THRESH=0, which is illegal), overflow_err=0, underflow_err=0.
- Read latency: rd_acc at edge N gives dout/dout_valid valid after edge N, for one cycle.
- Write-to-read: write accepted at edge N; fifo_empty falls after N; earliest read accept at N+1; data appears after N+1.
- Flag update: every flag and occupancy reflects accepted operations one edge after acceptance.
- Back-to-back: one write and one read can be accepted every cycle indefinitely.

## Configuration
- Macro SFIFO_PARAM_ERR_FLAGS_EN.
- Defined:
  - overflow_err sets on any edge with write_busy & fifo_full.
  - underflow_err sets on any edge with read_busy & fifo_empty.
  - Both hold until flush or reset.
- Not defined: overflow_err and underflow_err are tied to 0 and no error logic is built. Rejected requests are still dropped silently as described above.

## Test plan
- Reset, then write 0x1..0x8 on consecutive cycles → occupancy=8, fifo_empty=0, almost_empty=0 one edge after the last write.
- Fill DEPTH=8 (DEPTH_LOG2=3) then write 0xDEAD → fifo_full=1, write dropped; drain all → 8 words in order with dout_valid each cycle, never 0xDEAD. overflow_err=1 only when SFIFO_PARAM_ERR_FLAGS_EN is defined.
- Continuous simultaneous read/write for 3×DEPTH cycles from occupancy=4 → occupancy stays 4, data in order across pointer wrap.
- When empty, assert read_busy and write_busy with din=0x55 → read rejected, dout_valid=0, occupancy=1; next-cycle read → dout=0x55, dout_valid=1.
- At occupancy=5 assert fifo_flush together with write_busy → occupancy=0, fifo_empty=1, error flags cleared, dout unchanged.
- Assert reset_=0 for one cycle at occupancy=6 → all outputs at reset values after that edge; a write on the next edge is accepted.
